output_delta_gen: RTL
=====================

// Module: output_delta_gen
// PURPOSE
//  Output-layer error source for the training pipeline. Consumes last-layer FF results (sigmoid, sigmoid') plus ideal labels.
//  Computes per-neuron output deltas, buffers one full layer, then streams deltas to the BP/UP processor sets.
//  Also flags whether the sample was classified correctly (argmax check).
//  Sits between the last FF processor set and the first BP/UP stage.
// PARAMETERS
//  n          8   neurons in output layer; must be a multiple of z/fi
//  z          8   weights processed per cycle in last junction
//  fi         4   fan-in; z/fi (=zn) neurons per beat
//  width      16  data width, signed fixed point
//  int_bits   5   integer bits
//  frac_bits  10  fractional bits; 1.0 = 2**frac_bits
//  cost_type  0   0 = quadratic: delta=(a-y)*sp; 1 = cross-entropy: delta=(a-y)
// PORTS
//  clk            in   1          clock, rising edge
//  reset          in   1          asynchronous, active-low reset
//  in_valid       in   1          actn/sp/y beat valid
//  in_ready       out  1          block accepts an input beat
//  actn_package   in   width*zn   zn unsigned activations, neuron k at [width*(k+1)-1:width*k]
//  sp_package     in   width*zn   zn unsigned sigmoid-prime values
//  y_package      in   zn         ideal output bits; 1 -> 1.0, 0 -> 0.0
//  out_valid      out  1          delta beat valid
//  out_ready      in   1          downstream accepts delta beat
//  delta_package  out  width*zn   zn signed deltas, same packing as actn_package
//  out_idx        out  clog2(n/zn) beat index of delta_package
//  out_last       out  1          current out beat is the last of the layer
//  correct        out  1          argmax(actn)==argmax(y) for the buffered sample
//  done           out  1          1-cycle pulse when last out beat is accepted
// BEHAVIOUR
//  - Reset: state=FILL, counters 0, in_ready=1, out_valid=0, out_idx=0, out_last=0, correct=0, done=0, delta_package=0.
//  - FSM: FILL -> SERVE after accepting beat n/zn-1; SERVE -> FILL when beat with out_last is accepted.
//  - FILL: in_ready=1, out_valid=0. A beat is accepted on in_valid&&in_ready.
//    Its deltas are written to buffer slot wr_cnt in the same edge; wr_cnt increments.
//  - SERVE: in_ready=0, out_valid=1. delta_package, out_idx and out_last are registered from buffer slot rd_cnt.
//    rd_cnt advances only on out_valid&&out_ready. Holding out_ready low holds data and out_idx stable.
//  - done pulses the cycle after the final accept. in_ready returns to 1 in that same cycle, so no bubble is added.
//  - Throughput: n/zn input beats, then n/zn output beats. Input-to-first-output latency is 1 cycle after the last input accept.
//  - Arithmetic, per neuron: diff = a - y_fx, with y_fx = y ? 2**frac_bits : 0. diff is width+1 bits signed, so no overflow.
//    Quadratic: prod = diff*sp (2*width+1 bits), then arithmetic shift right by frac_bits.
//    Round half-up: add bit frac_bits-1 of prod.
//    Saturate to [-2**(width-1), 2**(width-1)-1].
//    Cross-entropy: delta = diff, saturated to width bits.
//  - Argmax: running max of actn across beats, with its neuron index. Ties keep the lowest index.
//    The index of the first y=1 bit is also tracked. correct is registered at FILL->SERVE and holds until the next FILL->SERVE.
//    If no y bit is set, correct=0.
//  - in_valid while in SERVE is ignored and not stored; the source must hold it.
//  - Reset asserted mid-fill or mid-serve discards the buffer and restarts FILL at beat 0.
//  - Buffer is n*width flops, not RAM, so BP can later index it combinationally.
// STRUCTURE
//  - Shared package: COST_QUADRATIC=0, COST_XENT=1, fixed-point ONE = 2**frac_bits, sat_width function.
//  - Sub-module delta_cell: one neuron's diff/mul/round/saturate, combinational, instantiated zn times via generate.
//  - Top holds the FSM, wr/rd counters, delta buffer, and argmax tracker.
// TESTING (n=8, z=8, fi=4 -> zn=2, width=16, frac_bits=10)
//  - Quadratic: a=768, y=1, sp=192 -> delta=-48 (0xFFD0). a=256, y=0, sp=192 -> delta=48.
//  - Cross-entropy build: a=768, y=1 -> delta=-256. a=1024, y=1 -> delta=0.
//  - 4 beats in, then out_ready held low 5 cycles -> out_valid=1, beat 0 stable, in_ready=0.
//    Release -> beats 0..3 out in order, out_last only on idx 3, done pulses once.
//  - Argmax: actn neuron 5 = 1000 (max), y bit 5 = 1 -> correct=1.
//    Move y to bit 2 -> correct=0. Equal max at neurons 1 and 6, y bit 1 -> correct=1.
//  - Saturation with width=8, frac_bits=4, int_bits=3: large sp makes the quadratic product overflow 8 bits -> delta clamps to -128 (0x80).
//  - Reset low during SERVE beat 1 -> async clear of out_valid and correct.
//    After release, 4 new beats fill and serve from idx 0.

Source files
------------

// File: rtl/output_delta_gen_pkg.sv
// Shared definitions for the output-layer delta generator: cost selectors,
// FSM state encoding and fixed-point helpers.
package output_delta_gen_pkg;

    localparam int COST_QUADRATIC = 0;
    localparam int COST_XENT      = 1;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    // Fixed-point 1.0 for a given number of fractional bits.
    function automatic int one_fx(input int frac_bits);
        return 1 << frac_bits;
    endfunction

    function automatic logic signed [63:0] sat_width(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/output_delta_gen_delta_cell.sv
// One output neuron's error term: (a - y) optionally scaled by sigmoid',
// rounded half-up back to the data format and saturated.
module output_delta_gen_delta_cell
    import output_delta_gen_pkg::*;
#(
    parameter int width     = 16,
    parameter int frac_bits = 10,
    parameter int cost_type = COST_QUADRATIC
) (
    input  logic [width-1:0]        i_actn,
    input  logic [width-1:0]        i_sp,
    input  logic                    i_y,
    output logic signed [width-1:0] o_delta
);

    localparam int PW = 2 * width + 2;

    logic signed [width:0]  w_one;
    logic signed [width:0]  w_diff;
    logic signed [PW-1:0]   w_prod;
    logic signed [PW-1:0]   w_half;
    logic signed [PW-1:0]   w_rsum;
    logic signed [PW-1:0]   w_shift;
    logic signed [63:0]     w_pre;
    logic signed [63:0]     w_sat;

    assign w_one  = (width + 1)'(one_fx(frac_bits));
    assign w_diff = $signed({1'b0, i_actn}) - (i_y ? w_one : '0);
    assign w_prod = w_diff * $signed({1'b0, i_sp});

    // Adding half an LSB before the arithmetic shift gives round-half-up.
    assign w_half  = PW'(one_fx(frac_bits) >> 1);
    assign w_rsum  = w_prod + w_half;
    assign w_shift = w_rsum >>> frac_bits;

    always_comb begin
        w_pre = 64'(w_shift);
        if (cost_type == COST_XENT) begin
            w_pre = 64'(w_diff);
        end
    end

    assign w_sat   = sat_width(w_pre, width);
    assign o_delta = width'(w_sat);

endmodule

// File: rtl/output_delta_gen.sv
// Output-layer delta source: buffers one layer of deltas while tracking the
// argmax check, then streams the deltas to the backprop stages.
module output_delta_gen
    import output_delta_gen_pkg::*;
#(
    parameter int n          = 8,
    parameter int z          = 8,
    parameter int fi         = 4,
    parameter int width      = 16,
    parameter int int_bits   = 5,
    parameter int frac_bits  = 10,
    parameter int cost_type  = COST_QUADRATIC,
    localparam int zn        = z / fi,
    localparam int NB        = n / zn,
    localparam int IDX_W     = (NB > 1) ? $clog2(NB) : 1,
    localparam int NIDX_W    = (n > 1) ? $clog2(n) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [width*zn-1:0]   actn_package,
    input  logic [width*zn-1:0]   sp_package,
    input  logic [zn-1:0]         y_package,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [width*zn-1:0]   delta_package,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_last,
    output logic                  correct,
    output logic                  done
);

    if ((int_bits + frac_bits + 1 != width) || (n % zn != 0) ||
        (cost_type != COST_QUADRATIC && cost_type != COST_XENT)) begin : g_param_err
        $error("output_delta_gen: inconsistent parameters");
    end

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       w_in_acc;
    logic                       w_out_acc;
    logic                       w_last_in;
    logic [IDX_W-1:0]           r_wr_cnt;
    logic [IDX_W-1:0]           r_rd_cnt;
    logic [IDX_W-1:0]           w_rd_nxt;
    logic [width*zn-1:0]        w_delta_pkg;
    logic [width*zn-1:0]        w_slot0;
    logic [NB-1:0][width*zn-1:0] r_buf;
    logic [width*zn-1:0]        r_delta_out;
    logic                       r_out_last;
    logic                       r_correct;
    logic                       r_done;
    logic [width-1:0]           r_max;
    logic [width-1:0]           w_max;
    logic [NIDX_W-1:0]          r_max_idx;
    logic [NIDX_W-1:0]          w_max_idx;
    logic                       r_y_found;
    logic                       w_y_found;
    logic [NIDX_W-1:0]          r_y_idx;
    logic [NIDX_W-1:0]          w_y_idx;

    for (genvar k = 0; k < zn; k++) begin : g_cell
        output_delta_gen_delta_cell #(
            .width     (width),
            .frac_bits (frac_bits),
            .cost_type (cost_type)
        ) u_cell (
            .i_actn  (actn_package[width*k +: width]),
            .i_sp    (sp_package[width*k +: width]),
            .i_y     (y_package[k]),
            .o_delta (w_delta_pkg[width*k +: width])
        );
    end

    assign w_last_in = (r_wr_cnt == IDX_W'(NB - 1));
    assign w_rd_nxt  = r_rd_cnt + IDX_W'(1);
    // A one-beat layer writes slot 0 on the same edge it must be presented.
    assign w_slot0   = (r_wr_cnt == '0) ? w_delta_pkg : r_buf[0];

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_in_acc    = 1'b0;
        w_out_acc   = 1'b0;
        case (r_state)
            ST_FILL: begin
                in_ready = 1'b1;
                w_in_acc = in_valid;
                if (w_in_acc && w_last_in) begin
                    w_state_nxt = ST_SERVE;
                end
            end
            ST_SERVE: begin
                out_valid = 1'b1;
                w_out_acc = out_ready;
                if (w_out_acc && r_out_last) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // Running argmax restarts on beat 0; strict compare keeps the lowest index on ties.
    always_comb begin
        w_max     = (r_wr_cnt == '0) ? '0   : r_max;
        w_max_idx = (r_wr_cnt == '0) ? '0   : r_max_idx;
        w_y_found = (r_wr_cnt == '0) ? 1'b0 : r_y_found;
        w_y_idx   = (r_wr_cnt == '0) ? '0   : r_y_idx;
        for (int k = 0; k < zn; k++) begin
            if (actn_package[width*k +: width] > w_max) begin
                w_max     = actn_package[width*k +: width];
                w_max_idx = NIDX_W'(int'(r_wr_cnt) * zn + k);
            end
            if (!w_y_found && y_package[k]) begin
                w_y_found = 1'b1;
                w_y_idx   = NIDX_W'(int'(r_wr_cnt) * zn + k);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_delta_out <= '0;
            r_out_last  <= 1'b0;
            r_correct   <= 1'b0;
            r_done      <= 1'b0;
            r_max       <= '0;
            r_max_idx   <= '0;
            r_y_found   <= 1'b0;
            r_y_idx     <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_in_acc) begin
                r_max     <= w_max;
                r_max_idx <= w_max_idx;
                r_y_found <= w_y_found;
                r_y_idx   <= w_y_idx;
                if (w_last_in) begin
                    r_wr_cnt    <= '0;
                    r_rd_cnt    <= '0;
                    r_delta_out <= w_slot0;
                    r_out_last  <= (NB == 1);
                    r_correct   <= w_y_found && (w_y_idx == w_max_idx);
                end else begin
                    r_wr_cnt <= r_wr_cnt + IDX_W'(1);
                end
            end
            if (w_out_acc) begin
                if (r_out_last) begin
                    r_rd_cnt   <= '0;
                    r_out_last <= 1'b0;
                    r_done     <= 1'b1;
                end else begin
                    r_rd_cnt    <= w_rd_nxt;
                    r_delta_out <= r_buf[w_rd_nxt];
                    r_out_last  <= (w_rd_nxt == IDX_W'(NB - 1));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_acc) begin
            r_buf[r_wr_cnt] <= w_delta_pkg;
        end
    end

    assign delta_package = r_delta_out;
    assign out_idx       = r_rd_cnt;
    assign out_last      = r_out_last;
    assign correct       = r_correct;
    assign done          = r_done;

endmodule
